work_loader: RTL

Upstream feeder of the mining core's input bundle (valid, newblock, hashstate, w1–w3). Accepts a work unit as a stream of 32-bit words over a valid/ready handshake and assembles it in a shadow register set. On a complete, well-formed unit it commits the unit atomically to the active outputs and pulses newblock. The core therefore never sees a partially loaded midstate.

---
 rtl/work_loader_pkg.sv | 29 ++
 rtl/work_shadow_regs.sv | 60 ++++++
 rtl/work_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/work_loader_pkg.sv
// Shared types and constants for the work-unit loader feeding the mining core.
// Optional checksum word is enabled with WORK_LOADER_XOR_CHECK_EN.
package work_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORK_WORDS     = 11;
    localparam int unsigned WORK_WORDS_CHK = 12;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned TAIL_IDX       = WORK_WORDS - 1;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] f;
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] h;
    } hash_state_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_CHECK  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/work_shadow_regs.sv
// Shadow register file for one work unit being assembled; the running XOR
// accumulator exists only when WORK_LOADER_XOR_CHECK_EN is defined.
module work_shadow_regs
    import work_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    output hash_state_t       shadow_hs,
    output logic [WORD_W-1:0] shadow_w1,
    output logic [WORD_W-1:0] shadow_w2,
    output logic [WORD_W-1:0] shadow_w3
`ifdef WORK_LOADER_XOR_CHECK_EN
    ,
    output logic [WORD_W-1:0] xor_acc
`endif
);

    logic [WORD_W-1:0] words [WORK_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(WORK_WORDS); i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(WORK_WORDS); i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    words[i] <= wr_data;
                end
            end
        end
    end

`ifdef WORK_LOADER_XOR_CHECK_EN
    // Word 0 restarts the checksum so a dropped unit never pollutes the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_acc <= '0;
        end else if (wr_en) begin
            xor_acc <= (wr_idx == '0) ? wr_data : (xor_acc ^ wr_data);
        end
    end
`endif

    assign shadow_hs.a = words[0];
    assign shadow_hs.b = words[1];
    assign shadow_hs.c = words[2];
    assign shadow_hs.d = words[3];
    assign shadow_hs.e = words[4];
    assign shadow_hs.f = words[5];
    assign shadow_hs.g = words[6];
    assign shadow_hs.h = words[7];
    assign shadow_w1   = words[8];
    assign shadow_w2   = words[9];
    assign shadow_w3   = words[10];

endmodule

// File: rtl/work_loader.sv
// Streams a work unit into shadow registers and commits it atomically to the core.
// Define WORK_LOADER_XOR_CHECK_EN to require a trailing XOR checksum word.
module work_loader
    import work_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              flush,
    output logic              core_valid,
    output logic              core_newblock,
    output hash_state_t       core_hashstate,
    output logic [WORD_W-1:0] core_w1,
    output logic [WORD_W-1:0] core_w2,
    output logic [WORD_W-1:0] core_w3,
    output logic              load_error
);

    loader_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              xfer_c;
    logic              wr_en_c;
    logic              commit_c;
    logic              err_c;
    hash_state_t       shadow_hs;
    logic [WORD_W-1:0] shadow_w1, shadow_w2, shadow_w3;
`ifdef WORK_LOADER_XOR_CHECK_EN
    logic [WORD_W-1:0] xor_acc;
`endif

    assign xfer_c = in_valid && in_ready;

    work_shadow_regs u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_c),
        .wr_idx    (cnt),
        .wr_data   (in_data),
        .shadow_hs (shadow_hs),
        .shadow_w1 (shadow_w1),
        .shadow_w2 (shadow_w2),
        .shadow_w3 (shadow_w3)
`ifdef WORK_LOADER_XOR_CHECK_EN
        ,
        .xor_acc   (xor_acc)
`endif
    );

    // Next-state, word count and strobes; flush overrides any transfer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en_c   = 1'b0;
        commit_c  = 1'b0;
        err_c     = 1'b0;
        if (flush) begin
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (xfer_c) begin
                        if (cnt != CNT_W'(TAIL_IDX)) begin
                            if (in_last) begin
                                err_c   = 1'b1;
                                cnt_nxt = '0;
                            end else begin
                                wr_en_c = 1'b1;
                                cnt_nxt = cnt + CNT_W'(1);
                            end
                        end else begin
                            wr_en_c = 1'b1;
                            cnt_nxt = '0;
`ifdef WORK_LOADER_XOR_CHECK_EN
                            if (in_last) begin
                                err_c = 1'b1;
                            end else begin
                                state_nxt = ST_CHECK;
                            end
`else
                            if (in_last) begin
                                state_nxt = ST_COMMIT;
                            end else begin
                                err_c     = 1'b1;
                                state_nxt = ST_DRAIN;
                            end
`endif
                        end
                    end
                end
`ifdef WORK_LOADER_XOR_CHECK_EN
                ST_CHECK: begin
                    if (xfer_c) begin
                        if (!in_last) begin
                            err_c     = 1'b1;
                            state_nxt = ST_DRAIN;
                        end else if (in_data == xor_acc) begin
                            state_nxt = ST_COMMIT;
                        end else begin
                            err_c     = 1'b1;
                            state_nxt = ST_LOAD;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    commit_c  = 1'b1;
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
                ST_DRAIN: begin
                    if (xfer_c && in_last) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Control registers; in_ready is low only while the commit cycle is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_LOAD;
            cnt           <= '0;
            in_ready      <= 1'b0;
            core_valid    <= 1'b0;
            core_newblock <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            in_ready      <= (state_nxt != ST_COMMIT);
            core_newblock <= commit_c;
            load_error    <= err_c;
            if (flush) begin
                core_valid <= 1'b0;
            end else if (commit_c) begin
                core_valid <= 1'b1;
            end
        end
    end

    // Active work seen by the core; only ever replaced as a whole.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_hashstate <= '0;
            core_w1        <= '0;
            core_w2        <= '0;
            core_w3        <= '0;
        end else if (commit_c) begin
            core_hashstate <= shadow_hs;
            core_w1        <= shadow_w1;
            core_w2        <= shadow_w2;
            core_w3        <= shadow_w3;
        end
    end

endmodule
